// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter: burst-limited two-port arbiter for a single-port data memory.
// Rev 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] C_BURST = CW'(BURST_MAX);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsel_q, rsel_d;
  logic          rpend_q, rpend_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt0, gnt1, gnt_any;

  // Contention: the owner keeps the memory until its burst budget is spent.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (cnt_q == C_BURST) begin
          gnt0 = owner_q;
          gnt1 = !owner_q;
        end else begin
          gnt0 = !owner_q;
          gnt1 = owner_q;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;
  assign mem_a   = gnt1 ? m1_addr  : m0_addr;
  assign mem_wd  = gnt1 ? m1_wdata : m0_wdata;
  assign mem_we  = gnt_any && (gnt1 ? m1_we : m0_we);

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rsel_d  = rsel_q;
    rpend_d = 1'b0;
    rdata_d = rdata_q;
    if (gnt_any) begin
      if (gnt1 == owner_q) begin
        if (cnt_q != C_BURST) cnt_d = cnt_q + C_ONE;
      end else begin
        owner_d = gnt1;
        cnt_d   = C_ONE;
      end
      if (!mem_we) begin
        rpend_d = 1'b1;
        rsel_d  = gnt1;
        rdata_d = mem_rd;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 1'b0;
      cnt_q   <= '0;
      rsel_q  <= 1'b0;
      rpend_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rsel_q  <= rsel_d;
      rpend_q <= rpend_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0_rvalid = rpend_q && !rsel_q && !reset;
  assign m1_rvalid = rpend_q &&  rsel_q && !reset;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter: directed + randomized checks of dmem_arbiter against a model.
// Rev 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // External memory: 256 words indexed by the low address byte.
  logic [DW-1:0] mem [256];
  logic          pl_en;
  logic [7:0]    pl_idx;

  function automatic logic [DW-1:0] pl_val(input logic [7:0] idx);
    if (idx == 8'h10) return 32'hDEADBEEF;
    return ({24'h0, idx} * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_a[7:0]] <= mem_wd;
    else if (pl_en) mem[pl_idx]     <= pl_val(pl_idx);
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            m_owner, m_cnt, m_pend, exp_g;
  logic [DW-1:0] m_rdata;
  logic          obs_g0, obs_g1;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cyc(input logic rs,
                     input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    int            g;
    logic          ewe;
    logic [31:0]   ea, ed;
    reset = rs;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #3;
    if (rs) begin
      m_owner = 0; m_cnt = 0; m_pend = -1; m_rdata = '0;
    end
    g = -1;
    if (!rs) begin
      if (r0 && r1)  g = (m_cnt >= BURST) ? 1 - m_owner : m_owner;
      else if (r0)   g = 0;
      else if (r1)   g = 1;
    end
    exp_g = g;
    ea  = (g == 1) ? a1 : a0;
    ed  = (g == 1) ? d1 : d0;
    ewe = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    check("m0_gnt", m0_gnt, g == 0);
    check("m1_gnt", m1_gnt, g == 1);
    check("mem_we", mem_we, ewe);
    check("mem_a", mem_a, ea);
    check("mem_wd", mem_wd, ed);
    check("m0_rvalid", m0_rvalid, m_pend == 0);
    check("m1_rvalid", m1_rvalid, m_pend == 1);
    check("m0_rdata", m0_rdata, m_rdata);
    check("m1_rdata", m1_rdata, m_rdata);
    obs_g0 = m0_gnt;
    obs_g1 = m1_gnt;
    if (!rs) begin
      if (g >= 0) begin
        if (ewe) begin
          ref_mem[ea[7:0]] = ed;
          m_pend = -1;
        end else begin
          m_rdata = ref_mem[ea[7:0]];
          m_pend  = g;
        end
        if (g == m_owner) m_cnt = (m_cnt + 1 > BURST) ? BURST : m_cnt + 1;
        else begin
          m_owner = g;
          m_cnt   = 1;
        end
      end else begin
        m_pend = -1;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  logic [11:0] pat;
  logic        p0_req, p0_we, p1_req, p1_we, rs;
  logic [31:0] p0_a, p0_d, p1_a, p1_d;

  initial begin
    pat = 12'b0000_1111_0000;
    reset = 1'b1; pl_en = 1'b1; pl_idx = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    m_owner = 0; m_cnt = 0; m_pend = -1; m_rdata = '0; exp_g = -1;
    for (int i = 0; i < 256; i++) begin
      pl_idx = i[7:0];
      ref_mem[i] = pl_val(i[7:0]);
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // Reset state, with requests present to prove gating
    cyc(1, 1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Single m0 read of the preloaded word
    cyc(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    idle();
    check("read_deadbeef", m0_rdata, 32'hDEADBEEF);

    // m1 write, then m0 reads it back
    cyc(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
    cyc(0, 1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    idle();
    check("readback_0x20", m0_rdata, 32'h12345678);

    // Continuous contention from reset: 4/4 burst alternation
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, $urandom % 256, 32'h0, 1, 0, $urandom % 256, 32'h0);
      check("burst_seq", obs_g1, pat[i]);
      check("one_hot", obs_g0 & obs_g1, 1'b0);
    end

    // Idle cycle clears the burst count; owner 0 keeps priority
    idle();
    cyc(0, 1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
    cyc(0, 1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
    idle();
    cyc(0, 1, 0, 32'hC, 32'h0, 1, 0, 32'h30, 32'h0);
    check("idle_clears_cnt", obs_g0, 1'b1);

    // Reset right after an m1 read grant drops the response
    cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    idle();
    idle();
    cyc(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
    check("post_reset_owner0", obs_g0, 1'b1);
    idle();

    // Alternating single-port reads every cycle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(0, 1, 0, $urandom % 256, 32'h0, 0, 0, 32'h0, 32'h0);
      else            cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, $urandom % 256, 32'h0);
    end
    idle();

    // Randomized traffic; requesters hold their request until granted
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_a = 0; p0_d = 0; p1_a = 0; p1_d = 0;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom % 80) == 0;
      if (!p0_req || exp_g == 0 || rs) begin
        p0_req = ($urandom % 4) != 0;
        p0_we  = $urandom % 2;
        p0_a   = $urandom % 256;
        p0_d   = $urandom;
      end
      if (!p1_req || exp_g == 1 || rs) begin
        p1_req = ($urandom % 4) != 0;
        p1_we  = $urandom % 2;
        p1_a   = $urandom % 256;
        p1_d   = $urandom;
      end
      cyc(rs, p0_req, p0_we, p0_a, p0_d, p1_req, p1_we, p1_a, p1_d);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
